fifo_wr_arbiter: RTL

Round-robin write arbiter that shares the single write port of a `FIFO_v` instance between `NUM_REQ` producers. It grants one producer at a time for a burst of up to `BURST_L` words. It gates every write on the FIFO `full` flag and muxes the winner's data onto the FIFO `data_in`/`wr_en` pins. It sits directly in front of the FIFO; the FIFO read side is untouched.

---
 rtl/fifo_arb_pkg.sv | 13 +
 rtl/rr_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter and its round-robin picker.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int unsigned BURST_CNT_W = 4;
  // Largest burst length the counter can track.
  localparam int unsigned BURST_L_MAX = 2 ** BURST_CNT_W;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted req searching upward from owner+1, wrapping.
module rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   owner,
  output logic [NUM_REQ-1:0] pick,
  output logic [IDX_W-1:0]   pick_idx,
  output logic               pick_vld
);

  // Above-owner slots win over the wrapped slots at or below owner.
  always_comb begin
    pick     = '0;
    pick_idx = owner;
    pick_vld = 1'b0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!pick_vld && req[i] && (IDX_W'(i) > owner)) begin
        pick_vld = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (!pick_vld && req[i] && (IDX_W'(i) <= owner)) begin
        pick_vld = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port between NUM_REQ producers.
// Optional FIFO_ARB_ALMST_THROTTLE_EN: hold off new grants while the FIFO is almost full.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 24,
  parameter int unsigned BURST_L = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [NUM_REQ-1:0]          ack,
  output logic [IDX_W-1:0]            owner,
  output logic                        busy,
  input  logic                        fifo_full,
  input  logic                        fifo_almst_full,
  output logic                        fifo_wr_en,
  output logic [DATA_W-1:0]           fifo_data_in
);

  localparam logic [BURST_CNT_W-1:0] LAST_CNT  = BURST_CNT_W'(BURST_L - 1);
  localparam logic [IDX_W-1:0]       OWNER_RST = IDX_W'(NUM_REQ - 1);

  if ((BURST_L < 1) || (BURST_L > BURST_L_MAX)) begin : g_bad_burst_l
    $error("fifo_wr_arbiter: BURST_L out of range");
  end

  arb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_d;
  logic [IDX_W-1:0]         owner_d;
  logic                     busy_d;
  logic [BURST_CNT_W-1:0]   cnt_q, cnt_d;
  logic                     owner_req;
  logic                     throttle;
  logic [NUM_REQ-1:0]       pick;
  logic [IDX_W-1:0]         pick_idx;
  logic                     pick_vld;

`ifdef FIFO_ARB_ALMST_THROTTLE_EN
  assign throttle = fifo_almst_full;
`else
  logic unused_almst_full;
  assign throttle          = 1'b0;
  assign unused_almst_full = fifo_almst_full;
`endif

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req      (req),
    .owner    (owner),
    .pick     (pick),
    .pick_idx (pick_idx),
    .pick_vld (pick_vld)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt     <= '0;
      owner   <= OWNER_RST;
      busy    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt     <= gnt_d;
      owner   <= owner_d;
      busy    <= busy_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write path follows the one-hot grant; reset blocks an in-flight word.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt;
    owner_d      = owner;
    busy_d       = busy;
    cnt_d        = cnt_q;
    ack          = '0;
    owner_req    = 1'b0;
    fifo_data_in = '0;

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (gnt[i]) begin
        owner_req    = req[i];
        fifo_data_in = req_data[i*DATA_W +: DATA_W];
        ack[i]       = req[i] & ~fifo_full & ~reset;
      end
    end
    fifo_wr_en = |ack;

    case (state_q)
      IDLE: begin
        if (pick_vld && !throttle) begin
          state_d = GRANT;
          gnt_d   = pick;
          owner_d = pick_idx;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        // A full FIFO with req held simply stalls here; the owner is never pre-empted.
        if (!owner_req || (fifo_wr_en && (cnt_q == LAST_CNT))) begin
          state_d = IDLE;
          gnt_d   = '0;
          busy_d  = 1'b0;
        end else if (fifo_wr_en) begin
          cnt_d = cnt_q + BURST_CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

endmodule
